// File: rtl/crt_clock_frac_divider.sv
// rtl/crt_clock_frac_divider.sv - fractional pixel-clock generator with enable gating and safe retuning
//
// Generates PixelClock with mean frequency CRTClockFreq from a system clock of
// SystemClockFreq (both in MHz) using a phase accumulator, so non-integer ratios
// are supported. Retuning and stopping happen only at the end of a pixel period.
//
// Ports:
//   Clock            in   system clock
//   Reset            in   synchronous, active-high
//   Enable           in   run request; low stops at the next clean period boundary
//   SystemClockFreq  in   system clock frequency, MHz
//   CRTClockFreq     in   requested pixel clock frequency, MHz
//   PixelClock       out  generated clock (registered), ~50% duty
//   PixelTick        out  one-cycle pulse on the cycle PixelClock goes 0->1
//   Running          out  high while the generator is in RUN
//   ConfigUpdated    out  one-cycle pulse when a new configuration is adopted
//   ConfigError      out  live inputs invalid: Sys==0, Crt==0 or 2*Crt>Sys

module crt_clock_frac_divider #(
    parameter int SystemClockSize = 10
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Enable,
    input  logic [SystemClockSize-1:0] SystemClockFreq,
    input  logic [SystemClockSize-1:0] CRTClockFreq,
    output logic                       PixelClock,
    output logic                       PixelTick,
    output logic                       Running,
    output logic                       ConfigUpdated,
    output logic                       ConfigError
);

    localparam int W = SystemClockSize;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state, state_n;
    // One bit wider than the frequencies so the accumulator, the increment and
    // their sum share a width; the top bit stays 0 because acc < act_sys.
    logic [W:0]     acc, acc_n;
    logic [W-1:0]   act_sys, act_sys_n;
    logic [W-1:0]   act_crt, act_crt_n;
    logic           pixel_clock, pixel_clock_n;
    logic           pixel_tick, pixel_tick_n;
    logic           config_updated, config_updated_n;
    logic           config_error;

    logic           valid;
    logic           changed;
    logic [W:0]     sum;
    logic [W:0]     sum_wrapped;
    logic           toggle;

    // 2*Crt <= Sys evaluated at W+1 bits so the doubling cannot overflow
    assign valid = (SystemClockFreq != '0) && (CRTClockFreq != '0) &&
                   ({CRTClockFreq, 1'b0} <= {1'b0, SystemClockFreq});

    assign changed = (SystemClockFreq != act_sys) || (CRTClockFreq != act_crt);

    assign sum         = acc + {act_crt, 1'b0};
    assign sum_wrapped = sum - {1'b0, act_sys};
    assign toggle      = (sum >= {1'b0, act_sys});

    always_comb begin
        state_n          = state;
        acc_n            = acc;
        act_sys_n        = act_sys;
        act_crt_n        = act_crt;
        pixel_clock_n    = pixel_clock;
        pixel_tick_n     = 1'b0;
        config_updated_n = 1'b0;

        case (state)
            IDLE: begin
                pixel_clock_n = 1'b0;
                acc_n         = '0;
                if (Enable && valid) begin
                    act_sys_n        = SystemClockFreq;
                    act_crt_n        = CRTClockFreq;
                    config_updated_n = 1'b1;
                    state_n          = RUN;
                end
            end

            RUN: begin
                if (toggle) begin
                    acc_n         = sum_wrapped;
                    pixel_clock_n = ~pixel_clock;
                    pixel_tick_n  = ~pixel_clock;
                end else begin
                    acc_n = sum;
                end

                // Period boundary: PixelClock falls this cycle, so stopping or
                // retuning here never produces a runt pulse.
                if (toggle && pixel_clock) begin
                    if (!Enable) begin
                        state_n = IDLE;
                        acc_n   = '0;
                    end else if (changed) begin
                        acc_n = '0;
                        if (valid) begin
                            act_sys_n        = SystemClockFreq;
                            act_crt_n        = CRTClockFreq;
                            config_updated_n = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_n       = IDLE;
                acc_n         = '0;
                pixel_clock_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            acc            <= '0;
            act_sys        <= '0;
            act_crt        <= '0;
            pixel_clock    <= 1'b0;
            pixel_tick     <= 1'b0;
            config_updated <= 1'b0;
            config_error   <= 1'b0;
        end else begin
            state          <= state_n;
            acc            <= acc_n;
            act_sys        <= act_sys_n;
            act_crt        <= act_crt_n;
            pixel_clock    <= pixel_clock_n;
            pixel_tick     <= pixel_tick_n;
            config_updated <= config_updated_n;
            config_error   <= ~valid;
        end
    end

    assign PixelClock    = pixel_clock;
    assign PixelTick     = pixel_tick;
    assign Running       = (state == RUN);
    assign ConfigUpdated = config_updated;
    assign ConfigError   = config_error;

endmodule

// File: tb/tb_crt_clock_frac_divider.sv
// tb/tb_crt_clock_frac_divider.sv - directed self-checking bench for crt_clock_frac_divider

module tb_crt_clock_frac_divider;

    logic       Clock;
    logic       Reset;
    logic       Enable;
    logic [9:0] SystemClockFreq;
    logic [9:0] CRTClockFreq;
    logic       PixelClock;
    logic       PixelTick;
    logic       Running;
    logic       ConfigUpdated;
    logic       ConfigError;

    int tests_run;
    int tests_failed;

    crt_clock_frac_divider #(.SystemClockSize(10)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Enable          (Enable),
        .SystemClockFreq (SystemClockFreq),
        .CRTClockFreq    (CRTClockFreq),
        .PixelClock      (PixelClock),
        .PixelTick       (PixelTick),
        .Running         (Running),
        .ConfigUpdated   (ConfigUpdated),
        .ConfigError     (ConfigError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one system cycle and land on the falling edge for sampling
    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    logic [15:0] pc_hist;
    logic [15:0] tick_hist;
    int          cu_count;
    int          rises;
    int          ticks;
    int          run_len;
    int          min_w;
    int          max_w;
    int          runs_seen;
    logic        prev_pc;

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        Reset           = 1'b1;
        Enable          = 1'b0;
        SystemClockFreq = 10'd100;
        CRTClockFreq    = 10'd25;
        step();
        step();

        // Reset state
        check("rst_pclk",  PixelClock,    0);
        check("rst_tick",  PixelTick,     0);
        check("rst_run",   Running,       0);
        check("rst_cu",    ConfigUpdated, 0);
        check("rst_err",   ConfigError,   0);

        // T1: 100/25 -> period 4, 2 high / 2 low
        Reset  = 1'b0;
        Enable = 1'b1;
        step();
        check("t1_running", Running,       1);
        check("t1_cu",      ConfigUpdated, 1);
        pc_hist   = '0;
        tick_hist = '0;
        cu_count  = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            pc_hist   = {pc_hist[14:0], PixelClock};
            tick_hist = {tick_hist[14:0], PixelTick};
            cu_count += int'(ConfigUpdated);
        end
        check("t1_pclk_pattern", pc_hist,   16'h6666);
        check("t1_tick_pattern", tick_hist, 16'h4444);
        check("t1_cu_once",      cu_count,  0);

        // T5: change Crt to 50 while PixelClock is high
        step();                       // k=17, low
        step();                       // k=18, rising
        check("t5_high_before", PixelClock, 1);
        CRTClockFreq = 10'd50;
        step();                       // k=19, still old config
        check("t5_hold_pclk", PixelClock,    1);
        check("t5_hold_cu",   ConfigUpdated, 0);
        step();                       // k=20, boundary adopts new config
        check("t5_fall_pclk", PixelClock,    0);
        check("t5_adopt_cu",  ConfigUpdated, 1);
        pc_hist   = '0;
        tick_hist = '0;
        cu_count  = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            pc_hist   = {pc_hist[14:0], PixelClock};
            tick_hist = {tick_hist[14:0], PixelTick};
            cu_count += int'(ConfigUpdated);
        end
        check("t5_pclk_period2", pc_hist[7:0],   8'hAA);
        check("t5_tick_period2", tick_hist[7:0], 8'hAA);
        check("t5_cu_quiet",     cu_count,       0);

        // T6b: Reset mid-run while PixelClock is high
        step();
        check("t6_pre_reset_high", PixelClock, 1);
        Reset        = 1'b1;
        CRTClockFreq = 10'd25;
        step();
        check("t6_rst_pclk", PixelClock,    0);
        check("t6_rst_tick", PixelTick,     0);
        check("t6_rst_run",  Running,       0);
        check("t6_rst_cu",   ConfigUpdated, 0);
        check("t6_rst_err",  ConfigError,   0);

        // T6a: drop Enable mid-high-phase at 100/25
        Reset = 1'b0;
        step();                       // enters RUN
        step();                       // k=1
        step();                       // k=2, rising
        check("t6_high", PixelClock, 1);
        Enable = 1'b0;
        step();                       // k=3, high phase continues
        check("t6_hold_pclk", PixelClock, 1);
        check("t6_hold_run",  Running,    1);
        step();                       // k=4, boundary -> IDLE
        check("t6_stop_pclk", PixelClock, 0);
        check("t6_stop_run",  Running,    0);
        step();
        check("t6_idle_pclk", PixelClock, 0);
        check("t6_idle_run",  Running,    0);

        // T3: 50/25 -> toggle every cycle
        SystemClockFreq = 10'd50;
        CRTClockFreq    = 10'd25;
        Enable          = 1'b1;
        step();
        check("t3_running", Running,       1);
        check("t3_cu",      ConfigUpdated, 1);
        pc_hist   = '0;
        tick_hist = '0;
        for (int k = 1; k <= 8; k++) begin
            step();
            pc_hist   = {pc_hist[14:0], PixelClock};
            tick_hist = {tick_hist[14:0], PixelTick};
        end
        check("t3_pclk_toggle", pc_hist[7:0],   8'hAA);
        check("t3_tick_toggle", tick_hist[7:0], 8'hAA);

        // T2: 100/30 -> 30 rising edges per 100 RUN cycles, widths in {1,2}
        Reset = 1'b1;
        step();
        Reset           = 1'b0;
        SystemClockFreq = 10'd100;
        CRTClockFreq    = 10'd30;
        Enable          = 1'b1;
        step();
        check("t2_running", Running, 1);
        rises     = 0;
        ticks     = 0;
        prev_pc   = 1'b0;
        run_len   = 0;
        runs_seen = 0;
        min_w     = 1000;
        max_w     = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (PixelClock && !prev_pc) rises++;
            ticks += int'(PixelTick);
            if (PixelClock == prev_pc) begin
                run_len++;
            end else begin
                // The first run starts before RUN and is skipped
                if (runs_seen > 0) begin
                    if (run_len < min_w) min_w = run_len;
                    if (run_len > max_w) max_w = run_len;
                end
                runs_seen++;
                run_len = 1;
            end
            prev_pc = PixelClock;
        end
        check("t2_rises", rises, 30);
        check("t2_ticks", ticks, 30);
        check("t2_min_w", min_w, 1);
        check("t2_max_w", max_w, 2);

        // T4: invalid configurations never start the generator
        Reset = 1'b1;
        step();
        Reset           = 1'b0;
        SystemClockFreq = 10'd100;
        CRTClockFreq    = 10'd60;
        Enable          = 1'b1;
        step();
        step();
        step();
        check("t4a_err",  ConfigError, 1);
        check("t4a_run",  Running,     0);
        check("t4a_pclk", PixelClock,  0);
        CRTClockFreq = 10'd0;
        step();
        step();
        check("t4b_err",  ConfigError, 1);
        check("t4b_run",  Running,     0);
        check("t4b_pclk", PixelClock,  0);
        CRTClockFreq = 10'd50;
        step();
        check("t4c_err_clear", ConfigError, 0);
        check("t4c_start",     Running,     1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
